// File: rtl/pipe_acc.sv
// Accumulation stage of the fixed-point matmul pipeline.
// Sums DIM product terms per element; emits row-major tagged elements.
module pipe_acc #(
  parameter int WORD_LEN = 32,
  parameter int DIM      = 4,
  parameter int GUARD    = 4,
  localparam int IW      = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_data,
  output logic [IW-1:0]       out_row,
  output logic [IW-1:0]       out_col,
  output logic                out_last,
  output logic                sat_flag
);

  localparam int AW = WORD_LEN + GUARD;

  logic [AW-1:0]       acc;
  logic [IW-1:0]       k;
  logic [IW-1:0]       i;
  logic [IW-1:0]       j;
  logic [AW-1:0]       sum;
  logic                last_k;
  logic                last_i;
  logic                last_j;
  logic                take;
  logic                sat;
  logic [WORD_LEN-1:0] sat_val;

  assign last_k = (k == IW'(DIM - 1));
  assign last_i = (i == IW'(DIM - 1));
  assign last_j = (j == IW'(DIM - 1));

  assign in_ready = !last_k || !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  assign sum = acc + {{GUARD{in_data[WORD_LEN-1]}}, in_data};

  // Out of range when the guard bits and the word sign bit disagree
  assign sat = !((&sum[AW-1:WORD_LEN-1]) || !(|sum[AW-1:WORD_LEN-1]));

  always_comb begin
    sat_val = sum[WORD_LEN-1:0];
    if (sat)
      sat_val = sum[AW-1] ? {1'b1, {(WORD_LEN-1){1'b0}}}
                          : {1'b0, {(WORD_LEN-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      k         <= '0;
      i         <= '0;
      j         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (take) begin
        if (last_k) begin
          out_data  <= sat_val;
          out_row   <= i;
          out_col   <= j;
          out_last  <= last_i && last_j;
          out_valid <= 1'b1;
          acc       <= '0;
          k         <= '0;
          if (sat)
            sat_flag <= 1'b1;
          if (last_j) begin
            j <= '0;
            i <= last_i ? '0 : i + IW'(1);
          end else begin
            j <= j + IW'(1);
          end
        end else begin
          acc <= sum;
          k   <= k + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_acc.sv
// Bench for pipe_acc: directed scenarios plus random traffic
// against a queue-based element model.
module tb_pipe_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last;
  logic        sat_flag;

  always #5 clk = ~clk;

  pipe_acc #(.WORD_LEN(32), .DIM(4), .GUARD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_last (out_last),
    .sat_flag (sat_flag)
  );

  typedef struct {
    logic [31:0] d;
    int          r;
    int          c;
    bit          l;
  } elem_t;

  elem_t  q[$];
  int     m_k;
  longint m_sum;
  int     m_n;
  bit     m_sat;
  int     nchk;
  int     nerr;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_k   = 0;
    m_sum = 0;
    m_n   = 0;
    m_sat = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd7;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    model_clear();
    #1;
    check("rst_vld", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_row", out_row, 0);
    check("rst_col", out_col, 0);
    check("rst_last", out_last, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_rdy", in_ready, 1);
  endtask

  // One clock: drive, check against model, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] d,
                       input logic r, output bit accepted);
    elem_t e;
    bit    exp_rdy;
    bit    take;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy = (m_k != 3) || (q.size() == 0) || r;
    check("vld", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("data", out_data, q[0].d);
      check("row", out_row, q[0].r);
      check("col", out_col, q[0].c);
      check("last", out_last, q[0].l);
    end
    check("rdy", in_ready, exp_rdy);
    check("sat", sat_flag, m_sat);
    take     = (q.size() != 0) && r;
    accepted = v && exp_rdy;
    if (take)
      void'(q.pop_front());
    if (accepted) begin
      m_sum += longint'($signed(d));
      m_k++;
      if (m_k == 4) begin
        if (m_sum > 64'sd2147483647) begin
          e.d   = 32'h7FFF_FFFF;
          m_sat = 1;
        end else if (m_sum < -64'sd2147483648) begin
          e.d   = 32'h8000_0000;
          m_sat = 1;
        end else begin
          e.d = m_sum[31:0];
        end
        e.r = (m_n / 4) % 4;
        e.c = m_n % 4;
        e.l = (m_n % 16) == 15;
        q.push_back(e);
        m_n++;
        m_k   = 0;
        m_sum = 0;
      end
    end
  endtask

  task automatic send(input logic [31:0] d, input logic r);
    bit a;
    cycle(1'b1, d, r, a);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) cycle(1'b0, 32'd0, 1'b1, a);
  endtask

  task automatic elem4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    send(a, 1'b1);
    send(b, 1'b1);
    send(c, 1'b1);
    send(d, 1'b1);
  endtask

  function automatic logic [31:0] rand_term();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 200)) - 32'd100;
      1:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
      2:       return 32'h8000_0000 + 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit a;
    nchk      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    do_reset();

    elem4(32'd1, 32'd2, 32'd3, 32'd4);
    idle(2);
    elem4(-32'sd5, 32'd3, -32'sd7, 32'd2);
    idle(2);
    elem4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    elem4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    elem4(32'd1, 32'd1, 32'd1, 32'd1);
    idle(2);

    do_reset();
    elem4(32'd1, 32'd2, 32'd3, 32'd4);
    send(32'd5, 1'b0);
    send(32'd5, 1'b0);
    send(32'd5, 1'b0);
    cycle(1'b1, 32'd5, 1'b0, a);
    check("stall", a, 0);
    cycle(1'b1, 32'd5, 1'b0, a);
    check("stall2", a, 0);
    cycle(1'b1, 32'd5, 1'b1, a);
    check("unstall", a, 1);
    idle(2);

    do_reset();
    repeat (64) send(32'd1, 1'b1);
    idle(1);
    elem4(32'd2, 32'd2, 32'd2, 32'd2);
    idle(2);

    do_reset();
    send(32'd7, 1'b1);
    send(32'd7, 1'b1);
    do_reset();
    idle(2);
    elem4(32'd1, 32'd1, 32'd1, 32'd1);
    idle(2);

    do_reset();
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 9) < 8, rand_term(),
            $urandom_range(0, 9) < 6, a);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
